sram_sp_be_arb: RTL and testbench

Parametrised single-port SRAM with byte-enable writes and a multi-requester front end. It arbitrates NUM_PORTS request/grant/rvalid channels round-robin onto one behavioural memory array, with a selectable output register. It sits between the core's instruction/data/debug masters and on-chip memory, and replaces fixed-geometry SRAM wrappers.

---
 rtl/sram_sp_be_arb.sv | 163 ++++++++++++++++
 tb/tb_sram_sp_be_arb.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_sp_be_arb.sv
// Single-port byte-enable SRAM shared by NUM_PORTS requesters through a round-robin arbiter.
// Every accepted request returns one rvalid pulse; write responses carry zero data.
module sram_sp_be_arb #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 2,
  parameter int OUT_REG    = 0
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [NUM_PORTS-1:0]              req_i,
  input  logic [NUM_PORTS-1:0]              we_i,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] be_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
  output logic [NUM_PORTS-1:0]              gnt_o,
  output logic [NUM_PORTS-1:0]              rvalid_o,
  output logic [DATA_WIDTH-1:0]             rdata_o
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [NUM_PORTS-1:0]  gnt_raw;
  logic [PW-1:0]         sel;
  logic                  accept;
  logic                  sel_we;
  logic [NB-1:0]         sel_be;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  generate
    if (NUM_PORTS == 1) begin : g_single
      assign gnt_raw = req_i;
      assign sel     = '0;
    end else begin : g_rr
      logic [PW-1:0] rr_reg;
      logic [PW-1:0] idx;

      // Walk from lowest to highest priority so the last hit is the winner.
      always_comb begin
        gnt_raw = '0;
        sel     = '0;
        idx     = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
          idx = PW'((int'(rr_reg) + i) % NUM_PORTS);
          if (req_i[idx]) begin
            gnt_raw      = '0;
            gnt_raw[idx] = 1'b1;
            sel          = idx;
          end
        end
      end

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          rr_reg <= '0;
        end else if (accept) begin
          rr_reg <= (int'(sel) == NUM_PORTS - 1) ? '0 : sel + PW'(1);
        end
      end
    end
  endgenerate

  assign gnt_o  = RST ? '0 : gnt_raw;
  assign accept = |gnt_o;

  always_comb begin
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (p == int'(sel)) begin
        sel_we    = we_i[p];
        sel_be    = be_i[p*NB +: NB];
        sel_addr  = addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Array and its read register carry no reset so they map onto block RAM.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word_reg;

  always_ff @(posedge CLK) begin
    if (accept) begin
      if (sel_we) begin
        for (int b = 0; b < NB; b++) begin
          if (sel_be[b]) begin
            mem[sel_addr][b*8 +: 8] <= sel_wdata[b*8 +: 8];
          end
        end
      end else begin
        rd_word_reg <= mem[sel_addr];
      end
    end
  end

  logic          v0_reg;
  logic          rd0_reg;
  logic [PW-1:0] p0_reg;
  logic [DATA_WIDTH-1:0] d0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v0_reg  <= 1'b0;
      rd0_reg <= 1'b0;
      p0_reg  <= '0;
    end else begin
      v0_reg  <= accept;
      rd0_reg <= accept & ~sel_we;
      p0_reg  <= sel;
    end
  end

  // Write responses and idle cycles present zero data.
  assign d0 = (v0_reg && rd0_reg) ? rd_word_reg : '0;

  logic                  out_v;
  logic [PW-1:0]         out_p;
  logic [DATA_WIDTH-1:0] out_d;

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic                  v1_reg;
      logic [PW-1:0]         p1_reg;
      logic [DATA_WIDTH-1:0] d1_reg;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          v1_reg <= 1'b0;
          p1_reg <= '0;
          d1_reg <= '0;
        end else begin
          v1_reg <= v0_reg;
          p1_reg <= p0_reg;
          d1_reg <= d0;
        end
      end

      assign out_v = v1_reg;
      assign out_p = p1_reg;
      assign out_d = d1_reg;
    end else begin : g_noreg
      assign out_v = v0_reg;
      assign out_p = p0_reg;
      assign out_d = d0;
    end
  endgenerate

  always_comb begin
    rvalid_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rvalid_o[p] = out_v && (int'(out_p) == p);
    end
  end

  assign rdata_o = out_d;

endmodule

// File: tb/tb_sram_sp_be_arb.sv
// Bench for sram_sp_be_arb: instance A (32b, 2 ports, latency 1) and instance B (64b, 3 ports, latency 2)
// checked every cycle against a behavioural model plus directed scenarios and random traffic.
module tb_sram_sp_be_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst;
  logic [2:0]  req   [2];
  logic [2:0]  we    [2];
  logic [7:0]  be    [2][3];
  logic [13:0] addr  [2][3];
  logic [63:0] wdata [2][3];

  logic [1:0]  gnt_a, rvalid_a;
  logic [31:0] rdata_a;
  logic [2:0]  gnt_b, rvalid_b;
  logic [63:0] rdata_b;

  sram_sp_be_arb #(.ADDR_WIDTH(14), .DATA_WIDTH(32), .NUM_PORTS(2), .OUT_REG(0)) dut_a (
    .CLK(clk), .RST(rst[0]),
    .req_i(req[0][1:0]), .we_i(we[0][1:0]),
    .be_i({be[0][1][3:0], be[0][0][3:0]}),
    .addr_i({addr[0][1], addr[0][0]}),
    .wdata_i({wdata[0][1][31:0], wdata[0][0][31:0]}),
    .gnt_o(gnt_a), .rvalid_o(rvalid_a), .rdata_o(rdata_a)
  );

  sram_sp_be_arb #(.ADDR_WIDTH(14), .DATA_WIDTH(64), .NUM_PORTS(3), .OUT_REG(1)) dut_b (
    .CLK(clk), .RST(rst[1]),
    .req_i(req[1]), .we_i(we[1]),
    .be_i({be[1][2], be[1][1], be[1][0]}),
    .addr_i({addr[1][2], addr[1][1], addr[1][0]}),
    .wdata_i({wdata[1][2], wdata[1][1], wdata[1][0]}),
    .gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b)
  );

  // Behavioural model: memory by (instance,address), priority pointer, per-edge response log.
  int          n_checks = 0;
  int          n_fail   = 0;
  int          e = 0;
  int          rr_m   [2];
  int          exp_g  [2];
  int          last_g [2];
  bit          hv [2][4];
  int          hp [2][4];
  logic [63:0] hd [2][4];
  bit          hk [2][4];
  logic [63:0] mem_m [int];
  logic [7:0]  kn_m  [int];

  function automatic int np(int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic int nb(int k);
    return (k == 0) ? 4 : 8;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr_hist(int k);
    for (int s = 0; s < 4; s++) hv[k][s] = 1'b0;
  endtask

  // Runs at the falling edge: outputs visible now versus model.
  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      int g;
      int s;
      int idx;
      logic [2:0]  eg, ev, ag, av;
      logic [63:0] ad;
      g = -1;
      if (!rst[k]) begin
        for (int i = 0; i < np(k); i++) begin
          idx = (rr_m[k] + i) % np(k);
          if (g < 0 && req[k][idx]) g = idx;
        end
      end
      exp_g[k] = g;
      eg = (g < 0) ? 3'b000 : 3'(1 << g);
      ag = (k == 0) ? {1'b0, gnt_a} : gnt_b;
      av = (k == 0) ? {1'b0, rvalid_a} : rvalid_b;
      ad = (k == 0) ? {32'b0, rdata_a} : rdata_b;
      s  = (e + 4 - k) % 4;
      ev = hv[k][s] ? 3'(1 << hp[k][s]) : 3'b000;
      chk($sformatf("gnt_%0d", k), 64'(ag), 64'(eg));
      chk($sformatf("rvalid_%0d", k), 64'(av), 64'(ev));
      if (!hv[k][s]) chk($sformatf("rdata_idle_%0d", k), ad, 64'h0);
      else if (hk[k][s]) chk($sformatf("rdata_%0d", k), ad, hd[k][s]);
    end
  endtask

  // Runs just after the rising edge: apply the transaction accepted at that edge.
  task automatic update();
    e++;
    for (int k = 0; k < 2; k++) begin
      int s;
      int g;
      int key;
      logic [63:0] t;
      logic [7:0]  km;
      s = e % 4;
      if (rst[k]) begin
        rr_m[k] = 0;
        last_g[k] = -1;
        clr_hist(k);
      end else begin
        g = exp_g[k];
        last_g[k] = g;
        hv[k][s] = 1'b0;
        if (g >= 0) begin
          key = k * 16384 + int'(addr[k][g]);
          t   = mem_m.exists(key) ? mem_m[key] : 64'h0;
          km  = kn_m.exists(key) ? kn_m[key] : 8'h0;
          hv[k][s] = 1'b1;
          hp[k][s] = g;
          if (we[k][g]) begin
            for (int b = 0; b < nb(k); b++) begin
              if (be[k][g][b]) begin
                t[8*b +: 8] = wdata[k][g][8*b +: 8];
                km[b] = 1'b1;
              end
            end
            mem_m[key] = t;
            kn_m[key]  = km;
            hd[k][s] = 64'h0;
            hk[k][s] = 1'b1;
            $display("dut%0d port%0d WR addr=%h be=%h data=%h", k, g, addr[k][g], be[k][g], wdata[k][g]);
          end else begin
            hd[k][s] = t;
            hk[k][s] = (km == ((k == 0) ? 8'h0F : 8'hFF));
            $display("dut%0d port%0d RD addr=%h data=%h", k, g, addr[k][g], t);
          end
          rr_m[k] = (g + 1) % np(k);
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    update();
  endtask

  task automatic issue(int k, int p, bit w, logic [7:0] b, logic [13:0] a, logic [63:0] d);
    bit ok;
    ok = 1'b0;
    req[k][p] = 1'b1; we[k][p] = w; be[k][p] = b; addr[k][p] = a; wdata[k][p] = d;
    for (int t = 0; t < 20 && !ok; t++) begin
      step();
      if (last_g[k] == p) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: dut%0d port%0d got no grant, required one within 20 cycles", k, p);
    end
    req[k][p] = 1'b0;
  endtask

  task automatic drive_random();
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < np(k); p++) begin
        if (!req[k][p] || last_g[k] == p) begin
          if ($urandom % 3 == 0) begin
            req[k][p] = 1'b0;
          end else begin
            req[k][p]   = 1'b1;
            we[k][p]    = 1'($urandom % 2);
            be[k][p]    = 8'($urandom);
            addr[k][p]  = ($urandom % 4 == 0) ? 14'h3FFF : 14'($urandom % 16);
            wdata[k][p] = {$urandom, $urandom};
          end
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    rst = 2'b11;
    for (int k = 0; k < 2; k++) begin
      req[k] = '0; we[k] = '0;
      rr_m[k] = 0; exp_g[k] = -1; last_g[k] = -1;
      clr_hist(k);
      for (int p = 0; p < 3; p++) begin
        be[k][p] = '0; addr[k][p] = '0; wdata[k][p] = '0;
      end
    end
    step();
    step();
    #2;
    chk("reset_gnt_a", 64'(gnt_a), 64'h0);
    chk("reset_rvalid_b", 64'(rvalid_b), 64'h0);
    chk("reset_rdata_b", rdata_b, 64'h0);
    rst = 2'b00;
    step();

    // A: byte-enable merge, visible one cycle after grant
    issue(0, 0, 1'b1, 8'hF, 14'h10, 64'hAABBCCDD);
    issue(0, 0, 1'b1, 8'h5, 14'h10, 64'h11223344);
    issue(0, 0, 1'b0, 8'h0, 14'h10, 64'h0);
    chk("model_be_merge", hd[0][e % 4], 64'hAA22CC44);
    #3;
    chk("be_read_rvalid", 64'(rvalid_a), 64'h1);
    chk("be_read_rdata", 64'(rdata_a), 64'hAA22CC44);

    // A: preload low addresses, then read-after-write at the top of the array
    issue(0, 0, 1'b1, 8'hF, 14'h0, 64'hA0);
    issue(0, 1, 1'b1, 8'hF, 14'h1, 64'hA1);
    issue(0, 0, 1'b1, 8'hF, 14'h3FFF, 64'h12345678);
    issue(0, 0, 1'b0, 8'h0, 14'h3FFF, 64'h0);
    chk("model_raw_top", hd[0][e % 4], 64'h12345678);

    // A: no-op write leaves contents untouched
    issue(0, 0, 1'b1, 8'hF, 14'h20, 64'h5);
    issue(0, 0, 1'b1, 8'h0, 14'h20, 64'hFFFFFFFF);
    chk("model_noop_resp", hd[0][e % 4], 64'h0);
    issue(0, 0, 1'b0, 8'h0, 14'h20, 64'h0);
    chk("model_noop_read", hd[0][e % 4], 64'h5);

    // A: both ports request continuously -> alternating grants
    req[0] = 3'b011; we[0] = 3'b000;
    addr[0][0] = 14'h0; addr[0][1] = 14'h1;
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (prev >= 0) chk("rr_alternate", 64'(last_g[0]), 64'((prev == 0) ? 1 : 0));
      chk("rr_read_data", hd[0][e % 4], (last_g[0] == 0) ? 64'hA0 : 64'hA1);
      prev = last_g[0];
    end
    chk("rr_first_after_port0", 64'(prev), 64'h0);
    req[0] = '0;

    // B: three ports requesting from reset -> 0,1,2,0,1,2
    for (int p = 0; p < 3; p++) begin
      req[1][p] = 1'b1; we[1][p] = 1'b1; be[1][p] = 8'hFF;
      addr[1][p] = 14'(p); wdata[1][p] = 64'(100 + p);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      chk("b_grant_order", 64'(last_g[1]), 64'(i % 3));
    end
    req[1] = '0;

    // B: upper-lane write and two-cycle latency
    issue(1, 0, 1'b1, 8'hFF, 14'h5, 64'h0123456789ABCDEF);
    issue(1, 0, 1'b1, 8'h80, 14'h5, 64'hFFFFFFFFFFFFFFFF);
    step();
    issue(1, 0, 1'b0, 8'h0, 14'h5, 64'h0);
    chk("model_b_lane7", hd[1][e % 4], 64'hFF23456789ABCDEF);
    #3;
    chk("b_latency_early", 64'(rvalid_b), 64'h0);
    step();
    #3;
    chk("b_latency_rvalid", 64'(rvalid_b), 64'h1);
    chk("b_latency_rdata", rdata_b, 64'hFF23456789ABCDEF);

    // B: reset with two reads in flight
    req[1][0] = 1'b1; we[1][0] = 1'b0; addr[1][0] = 14'h5;
    step();
    step();
    #1;
    rst[1] = 1'b1;
    rr_m[1] = 0;
    clr_hist(1);
    #1;
    chk("rst_rvalid_b", 64'(rvalid_b), 64'h0);
    chk("rst_rdata_b", rdata_b, 64'h0);
    chk("rst_gnt_b", 64'(gnt_b), 64'h0);
    req[1][1] = 1'b1; we[1][1] = 1'b0; addr[1][1] = 14'h0;
    step();
    step();
    rst[1] = 1'b0;
    step();
    chk("rst_first_grant", 64'(last_g[1]), 64'h0);
    req[1] = '0;
    for (int i = 0; i < 4; i++) step();

    // Random traffic on both instances
    for (int i = 0; i < 600; i++) begin
      drive_random();
      step();
    end
    req[0] = '0;
    req[1] = '0;
    for (int i = 0; i < 4; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
